// File: rtl/communication_tx_scheduler_if.sv
// Requester, serial-link and ack signals shared between the tx scheduler and its environment.
interface communication_tx_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              tx_data;
  logic              tx_freq;
  logic              tx_en;
  logic              rx_ready;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  req, req_data, rx_ready,
    output gnt, tx_data, tx_freq, tx_en, busy, err_timeout
  );

  modport slave (
    output req, req_data, rx_ready,
    input  gnt, tx_data, tx_freq, tx_en, busy, err_timeout
  );
endinterface

// File: rtl/communication_tx_scheduler.sv
// Round-robin arbiter plus serialiser: start, 8 data bits LSB first, parity, stop bits,
// then waits for the receiver's synchronised rx_ready rising edge or a timeout.
module communication_tx_scheduler #(
  parameter int NREQ        = 4,
  parameter int DIV         = 8,
  parameter int STOP_BITS   = 2,
  parameter int PARITY_ODD  = 0,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                        clk2,
  input  logic                        rst,
  communication_tx_scheduler_if.master bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_ACK
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      idx_reg, idx_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [7:0]      data_reg, data_next;
  logic            par_reg, par_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic            err_reg, err_next;
  logic            sync1_reg, sync2_reg, sync3_reg;

  logic [7:0]      req_byte [NREQ];
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic            in_bit;
  logic            bit_end;
  logic            ack_edge;
  logic            tx_bit;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Scan ptr+1, ptr+2, ... so the last winner has lowest priority next time.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_reg) + k) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign in_bit   = (state_reg == S_START) || (state_reg == S_DATA) ||
                    (state_reg == S_PARITY) || (state_reg == S_STOP);
  assign bit_end  = (cnt_reg == CW'(DIV - 1));
  assign ack_edge = sync2_reg & ~sync3_reg;

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      tmo_reg   <= '0;
      ptr_reg   <= PW'(NREQ - 1);
      data_reg  <= '0;
      par_reg   <= 1'b0;
      gnt_reg   <= '0;
      err_reg   <= 1'b0;
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      tmo_reg   <= tmo_next;
      ptr_reg   <= ptr_next;
      data_reg  <= data_next;
      par_reg   <= par_next;
      gnt_reg   <= gnt_next;
      err_reg   <= err_next;
      sync1_reg <= bus.rx_ready;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    tmo_next   = tmo_reg;
    ptr_next   = ptr_reg;
    data_next  = data_reg;
    par_next   = par_reg;
    gnt_next   = '0;
    err_next   = 1'b0;

    if (in_bit) begin
      cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (win_found) begin
          state_next = S_START;
          cnt_next   = '0;
          ptr_next   = win_idx;
          data_next  = req_byte[win_idx];
          par_next   = (PARITY_ODD != 0) ? ~^req_byte[win_idx] : ^req_byte[win_idx];
          gnt_next   = NREQ'(1) << win_idx;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          idx_next   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_reg == 3'd7) begin
            state_next = S_PARITY;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          idx_next   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_reg == 3'(STOP_BITS - 1)) begin
            state_next = S_WAIT_ACK;
            tmo_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        // An ack arriving on the timeout cycle takes precedence over the error.
        if (ack_edge) begin
          state_next = S_IDLE;
        end else if (tmo_reg == TW'(ACK_TIMEOUT - 1)) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    case (state_reg)
      S_START:  tx_bit = 1'b0;
      S_DATA:   tx_bit = data_reg[idx_reg];
      S_PARITY: tx_bit = par_reg;
      default:  tx_bit = 1'b1;
    endcase
  end

  // Bit clock high in the second half of each bit so the receiver samples mid-bit.
  assign bus.tx_data     = tx_bit;
  assign bus.tx_freq     = in_bit && (cnt_reg >= CW'(DIV / 2));
  assign bus.tx_en       = in_bit;
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.gnt         = gnt_reg;
  assign bus.err_timeout = err_reg;
endmodule

// File: tb/tb_communication_tx_scheduler.sv
// Scoreboard bench: stimulus queues expected grants/frames, monitors decode the line and compare.
module tb_communication_tx_scheduler;
  localparam int NREQ = 4;

  logic clk2 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk2 = ~clk2;

  communication_tx_scheduler_if #(.NREQ(NREQ)) bus_a ();
  communication_tx_scheduler_if #(.NREQ(NREQ)) bus_b ();

  communication_tx_scheduler #(.NREQ(NREQ)) dut_a (
    .clk2 (clk2),
    .rst  (rst),
    .bus  (bus_a.master)
  );

  communication_tx_scheduler #(.NREQ(NREQ), .PARITY_ODD(1)) dut_b (
    .clk2 (clk2),
    .rst  (rst),
    .bus  (bus_b.master)
  );

  typedef struct {
    int          idx;
    logic [11:0] frame;
  } exp_t;

  exp_t        q_a[$];
  logic [11:0] q_b[$];
  int          ack_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          err_cnt = 0;
  int          err_cyc = 0;
  int          wa_cyc = 0;
  logic        act_a = 1'b0;
  logic        act_b = 1'b0;

  always @(posedge clk2) cyc <= cyc + 1;

  function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic p);
    return {2'b11, p, d, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_a(input int idx, input logic [7:0] d, input logic p, input int ack);
    exp_t e;
    e.idx   = idx;
    e.frame = mk_frame(d, p);
    q_a.push_back(e);
    if (ack != -2) ack_q.push_back(ack);
  endtask

  task automatic wait_gnt(input int bsel, input int idx);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk2);
      seen = (bsel == 0) ? bus_a.gnt[idx] : bus_b.gnt[idx];
    end
    if (!seen) chk($sformatf("grant_wait_%0d_%0d", bsel, idx), 32'(seen), 1);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk2);
      done = (q_a.size() == 0) && (ack_q.size() == 0) && !act_a && !bus_a.busy &&
             !bus_a.rx_ready && (q_b.size() == 0) && !act_b && !bus_b.busy;
    end
    chk("drained", 32'(done), 1);
  endtask

  // Monitor for the even-parity instance: grants, decoded frames, timeout pulses.
  initial begin
    int          nb, en_n;
    logic [11:0] acc;
    logic        pf, pe;
    exp_t        cur;
    nb = 0; en_n = 0; acc = '1; pf = 1'b0; pe = 1'b0;
    cur.idx = 0; cur.frame = '0;
    forever begin
      @(negedge clk2);
      if (rst) begin
        act_a = 1'b0; nb = 0; pf = 1'b0; pe = 1'b0;
      end else begin
        if (bus_a.err_timeout) begin
          err_cnt++;
          err_cyc = cyc;
        end
        if (bus_a.gnt != '0) begin
          if (q_a.size() == 0) begin
            chk("unexpected_gnt", 32'(bus_a.gnt), 0);
          end else begin
            cur = q_a.pop_front();
            chk($sformatf("gnt_req%0d", cur.idx), 32'(bus_a.gnt), 32'(1) << cur.idx);
            act_a = 1'b1; nb = 0; en_n = 0; acc = '1;
          end
        end
        if (bus_a.tx_en) en_n++;
        if (bus_a.tx_freq && !pf) begin
          if (nb < 12) acc[nb[3:0]] = bus_a.tx_data;
          nb++;
        end
        if (pe && !bus_a.tx_en && act_a) begin
          chk($sformatf("frame_req%0d", cur.idx), 32'(acc), 32'(cur.frame));
          chk("freq_rises", nb, 12);
          chk("en_cycles", en_n, 96);
          act_a = 1'b0;
        end
        pf = bus_a.tx_freq;
        pe = bus_a.tx_en;
      end
    end
  end

  // Monitor for the odd-parity instance: frames only.
  initial begin
    int          nb;
    logic [11:0] acc, cur;
    logic        pf, pe;
    nb = 0; acc = '1; cur = '0; pf = 1'b0; pe = 1'b0;
    forever begin
      @(negedge clk2);
      if (rst) begin
        act_b = 1'b0; nb = 0; pf = 1'b0; pe = 1'b0;
      end else begin
        if (bus_b.tx_en && !pe) begin
          if (q_b.size() == 0) begin
            chk("unexpected_frame_odd", 32'(bus_b.tx_en), 0);
          end else begin
            cur = q_b.pop_front();
            act_b = 1'b1; nb = 0; acc = '1;
          end
        end
        if (bus_b.tx_freq && !pf) begin
          if (nb < 12) acc[nb[3:0]] = bus_b.tx_data;
          nb++;
        end
        if (pe && !bus_b.tx_en && act_b) begin
          chk("frame_odd", 32'(acc), 32'(cur));
          act_b = 1'b0;
        end
        pf = bus_b.tx_freq;
        pe = bus_b.tx_en;
      end
    end
  end

  // Receiver model: on WAIT_ACK entry pops an ack delay (-1 = stay silent).
  initial begin
    logic pe;
    int   d;
    pe = 1'b0;
    bus_a.rx_ready = 1'b0;
    forever begin
      @(negedge clk2);
      if (!rst && pe && !bus_a.tx_en && bus_a.busy) begin
        wa_cyc = cyc;
        if (ack_q.size() == 0) begin
          chk("unexpected_wait_ack", 32'(bus_a.busy), 0);
        end else begin
          d = ack_q.pop_front();
          if (d >= 0) begin
            repeat (d) @(negedge clk2);
            bus_a.rx_ready = 1'b1;
            repeat (4) @(negedge clk2);
            bus_a.rx_ready = 1'b0;
          end
        end
      end
      pe = bus_a.tx_en;
    end
  end

  initial begin
    repeat (50000) @(posedge clk2);
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.req = '0; bus_a.req_data = '0;
    bus_b.req = '0; bus_b.req_data = '0; bus_b.rx_ready = 1'b0;
    repeat (3) @(negedge clk2);
    chk("rst_tx_data", 32'(bus_a.tx_data), 1);
    chk("rst_tx_en", 32'(bus_a.tx_en), 0);
    chk("rst_tx_freq", 32'(bus_a.tx_freq), 0);
    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_gnt", 32'(bus_a.gnt), 0);
    chk("rst_err", 32'(bus_a.err_timeout), 0);
    rst = 1'b0;

    // Single byte A5: line 0,1,0,1,0,0,1,0,1,0,1,1; ack 20 cycles after WAIT_ACK entry.
    bus_a.req_data[7:0] = 8'hA5;
    push_a(0, 8'hA5, 1'b0, 20);
    bus_a.req = 4'b0001;
    wait_gnt(0, 0);
    bus_a.req = '0;
    wait_drain();
    chk("single_err_cnt", err_cnt, 0);

    // Reset mid-DATA: outputs go idle in the same cycle, pointer returns to NREQ-1.
    bus_a.req_data[23:16] = 8'h5A;
    push_a(2, 8'h5A, 1'b0, -2);
    bus_a.req = 4'b0100;
    wait_gnt(0, 2);
    bus_a.req = '0;
    repeat (30) @(negedge clk2);
    chk("abort_busy_before", 32'(bus_a.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx_data", 32'(bus_a.tx_data), 1);
    chk("abort_tx_en", 32'(bus_a.tx_en), 0);
    chk("abort_tx_freq", 32'(bus_a.tx_freq), 0);
    chk("abort_busy", 32'(bus_a.busy), 0);
    chk("abort_gnt", 32'(bus_a.gnt), 0);
    repeat (2) @(negedge clk2);
    rst = 1'b0;

    // Round robin with all requests held: 0,1,2,3,0.
    bus_a.req_data = {8'hFE, 8'h07, 8'h81, 8'h3C};
    push_a(0, 8'h3C, 1'b0, 20);
    push_a(1, 8'h81, 1'b0, 20);
    push_a(2, 8'h07, 1'b1, 20);
    push_a(3, 8'hFE, 1'b1, 20);
    push_a(0, 8'h3C, 1'b0, 20);
    bus_a.req = 4'b1111;
    wait_gnt(0, 0);
    wait_gnt(0, 1);
    wait_gnt(0, 2);
    wait_gnt(0, 3);
    wait_gnt(0, 0);
    bus_a.req = '0;
    wait_drain();

    // Timeout: no ack, err 64 cycles after WAIT_ACK entry; pending req 1 served next.
    bus_a.req_data[7:0] = 8'hC3;
    push_a(0, 8'hC3, 1'b0, -1);
    push_a(1, 8'h81, 1'b0, 20);
    bus_a.req = 4'b0001;
    wait_gnt(0, 0);
    bus_a.req = 4'b0010;
    wait_gnt(0, 1);
    chk("timeout_err_cnt", err_cnt, 1);
    chk("timeout_latency", err_cyc - wa_cyc, 64);
    bus_a.req = '0;
    wait_drain();

    // Ack edge lands on the timeout cycle: ack wins, no error.
    bus_a.req_data[7:0] = 8'h96;
    push_a(0, 8'h96, 1'b0, 61);
    bus_a.req = 4'b0001;
    wait_gnt(0, 0);
    bus_a.req = '0;
    wait_drain();
    chk("collision_err_cnt", err_cnt, 1);

    // Odd parity instance: 00 -> parity 1, 01 -> parity 0.
    bus_b.req_data[7:0] = 8'h00;
    q_b.push_back(mk_frame(8'h00, 1'b1));
    bus_b.req = 4'b0001;
    wait_gnt(1, 0);
    bus_b.req = '0;
    wait_drain();
    bus_b.req_data[7:0] = 8'h01;
    q_b.push_back(mk_frame(8'h01, 1'b0));
    bus_b.req = 4'b0001;
    wait_gnt(1, 0);
    bus_b.req = '0;
    wait_drain();

    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
